// File: rtl/model_transformer_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// model_transformer_scheduler_pkg
// Shared constants for the transformer-layer scheduler: FSM state encodings,
// default widths and the default memory map (W, B, X and H regions).
// ----------------------------------------------------------------------------
package model_transformer_scheduler_pkg;

    localparam int DATA_SIZE_DEF = 64;
    localparam int ADDR_SIZE_DEF = 16;

    localparam logic [15:0] W_BASE_DEF = 16'h0000;
    localparam logic [15:0] B_BASE_DEF = 16'h4000;
    localparam logic [15:0] X_BASE_DEF = 16'h6000;
    localparam logic [15:0] H_BASE_DEF = 16'h8000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_LOAD_W     = 3'd1;
    localparam state_t ST_LOAD_B     = 3'd2;
    localparam state_t ST_LOAD_X     = 3'd3;
    localparam state_t ST_RUN        = 3'd4;
    localparam state_t ST_WAIT_READY = 3'd5;
    localparam state_t ST_STORE_H    = 3'd6;
    localparam state_t ST_DONE       = 3'd7;

endpackage

// File: rtl/model_transformer_scheduler_fetch.sv
// ----------------------------------------------------------------------------
// model_transformer_scheduler_fetch
// Single-outstanding memory read engine shared by the three LOAD states.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req, i_addr         read request (taken only when o_busy is low)
//   i_mem_valid/rdata     memory response
//   o_mem_rd, o_mem_addr  one-cycle read strobe and its address
//   o_data, o_valid       registered read word, valid for one cycle
//   o_busy                a read is outstanding
//
// Handshake: a request is accepted on any edge where i_req=1 and o_busy=0;
// o_mem_rd pulses the following cycle. The first i_mem_valid seen after the
// read cycle completes the read; o_valid pulses the cycle after it and o_busy
// is already low then, so the next request can be issued in that same cycle.
// i_mem_valid with nothing outstanding is dropped.
// ----------------------------------------------------------------------------
module model_transformer_scheduler_fetch #(
    parameter int DATA_SIZE = 64,
    parameter int ADDR_SIZE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic                 i_mem_valid,
    input  logic [DATA_SIZE-1:0] i_mem_rdata,
    output logic                 o_mem_rd,
    output logic [ADDR_SIZE-1:0] o_mem_addr,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_busy
);

    logic                 r_rd;
    logic                 r_pend;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [DATA_SIZE-1:0] r_data;
    logic                 r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd    <= 1'b0;
            r_pend  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_rd    <= 1'b0;
            r_valid <= 1'b0;
            if (i_req && !r_pend) begin
                r_rd   <= 1'b1;
                r_addr <= i_addr;
                r_pend <= 1'b1;
            end else if (r_pend && !r_rd && i_mem_valid) begin
                // Latency is at least one, so valid during the read cycle itself is not ours.
                r_data  <= i_mem_rdata;
                r_valid <= 1'b1;
                r_pend  <= 1'b0;
            end
        end
    end

    assign o_mem_rd   = r_rd;
    assign o_mem_addr = r_addr;
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_busy     = r_pend;

endmodule

// File: rtl/model_transformer_scheduler.sv
// ----------------------------------------------------------------------------
// model_transformer_scheduler
// Sequences one transformer layer pass for model_controller: streams W, B and
// X from memory into the controller strobes, pulses START, waits for READY and
// writes the H_OUT results back to memory.
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   CMD_START/SIZE_X_IN/SIZE_L_IN command and sizes (sampled in IDLE)
//   CMD_BUSY/CMD_DONE/CMD_ERROR   command status
//   MEM_*                         word-addressed memory port
//   START/READY                   controller run handshake
//   W_IN_*, B_IN_*, X_IN_*        controller load strobes and data
//   H_OUT_ENABLE/H_OUT            controller result stream
//   DBG_STATE                     current FSM state
// ----------------------------------------------------------------------------
module model_transformer_scheduler
    import model_transformer_scheduler_pkg::*;
#(
    parameter int                   DATA_SIZE = DATA_SIZE_DEF,
    parameter int                   ADDR_SIZE = ADDR_SIZE_DEF,
    parameter logic [ADDR_SIZE-1:0] W_BASE    = W_BASE_DEF,
    parameter logic [ADDR_SIZE-1:0] B_BASE    = B_BASE_DEF,
    parameter logic [ADDR_SIZE-1:0] X_BASE    = X_BASE_DEF,
    parameter logic [ADDR_SIZE-1:0] H_BASE    = H_BASE_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMD_START,
    input  logic [DATA_SIZE-1:0] SIZE_X_IN,
    input  logic [DATA_SIZE-1:0] SIZE_L_IN,
    output logic                 CMD_BUSY,
    output logic                 CMD_DONE,
    output logic                 CMD_ERROR,
    output logic                 MEM_RD,
    output logic                 MEM_WR,
    output logic [ADDR_SIZE-1:0] MEM_ADDR,
    output logic [DATA_SIZE-1:0] MEM_WDATA,
    input  logic [DATA_SIZE-1:0] MEM_RDATA,
    input  logic                 MEM_VALID,
    output logic                 START,
    input  logic                 READY,
    output logic                 W_IN_L_ENABLE,
    output logic                 W_IN_X_ENABLE,
    output logic [DATA_SIZE-1:0] W_IN,
    output logic                 B_IN_ENABLE,
    output logic [DATA_SIZE-1:0] B_IN,
    output logic                 X_IN_ENABLE,
    output logic [DATA_SIZE-1:0] X_IN,
    input  logic                 H_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] H_OUT,
    output logic [2:0]           DBG_STATE
);

    localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

    state_t               r_state;
    logic [DATA_SIZE-1:0] r_size_x, r_size_l;
    logic [DATA_SIZE-1:0] r_l, r_x, r_i;
    logic [ADDR_SIZE-1:0] r_k;        // linear W offset l*SIZE_X + x, wraps naturally
    logic                 r_last;     // final element of the phase already requested/stored
    logic                 r_tag_row;  // element in flight is the first of its W row
    logic                 r_err;
    logic                 r_wr;
    logic [ADDR_SIZE-1:0] r_waddr;
    logic [DATA_SIZE-1:0] r_wdata;

    logic                 w_req;
    logic [ADDR_SIZE-1:0] w_req_addr;
    logic                 w_f_rd, w_f_valid, w_f_busy;
    logic [ADDR_SIZE-1:0] w_f_addr;
    logic [DATA_SIZE-1:0] w_f_data;
    logic                 w_size_zero;
    logic                 w_phase_end;

    assign w_size_zero = (SIZE_X_IN == '0) || (SIZE_L_IN == '0);
    assign w_phase_end = w_f_valid && r_last;

    always_comb begin
        w_req      = 1'b0;
        w_req_addr = '0;
        case (r_state)
            ST_LOAD_W: begin
                w_req      = !w_f_busy && !r_last;
                w_req_addr = W_BASE + r_k;
            end
            ST_LOAD_B: begin
                w_req      = !w_f_busy && !r_last;
                w_req_addr = B_BASE + r_i[ADDR_SIZE-1:0];
            end
            ST_LOAD_X: begin
                w_req      = !w_f_busy && !r_last;
                w_req_addr = X_BASE + r_i[ADDR_SIZE-1:0];
            end
            default: ;
        endcase
    end

    model_transformer_scheduler_fetch #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_fetch (
        .i_clk       (CLK),
        .i_rst_n     (RST),
        .i_req       (w_req),
        .i_addr      (w_req_addr),
        .i_mem_valid (MEM_VALID),
        .i_mem_rdata (MEM_RDATA),
        .o_mem_rd    (w_f_rd),
        .o_mem_addr  (w_f_addr),
        .o_data      (w_f_data),
        .o_valid     (w_f_valid),
        .o_busy      (w_f_busy)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_size_x  <= '0;
            r_size_l  <= '0;
            r_l       <= '0;
            r_x       <= '0;
            r_i       <= '0;
            r_k       <= '0;
            r_last    <= 1'b0;
            r_tag_row <= 1'b0;
            r_err     <= 1'b0;
            r_wr      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (CMD_START) begin
                        r_size_x <= SIZE_X_IN;
                        r_size_l <= SIZE_L_IN;
                        r_l      <= '0;
                        r_x      <= '0;
                        r_i      <= '0;
                        r_k      <= '0;
                        r_last   <= 1'b0;
                        r_err    <= w_size_zero;
                        r_state  <= w_size_zero ? ST_DONE : ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    // Counters advance when an element is requested; the row tag
                    // travels with the read so the strobe cycle can use it.
                    if (w_req) begin
                        r_tag_row <= (r_x == '0);
                        r_k       <= r_k + 1'b1;
                        if (r_x == r_size_x - ONE) begin
                            r_x <= '0;
                            if (r_l == r_size_l - ONE) r_last <= 1'b1;
                            else                       r_l    <= r_l + ONE;
                        end else begin
                            r_x <= r_x + ONE;
                        end
                    end
                    if (w_phase_end) begin
                        r_last  <= 1'b0;
                        r_i     <= '0;
                        r_state <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (w_req) begin
                        r_i <= r_i + ONE;
                        if (r_i == r_size_l - ONE) r_last <= 1'b1;
                    end
                    if (w_phase_end) begin
                        r_last  <= 1'b0;
                        r_i     <= '0;
                        r_state <= ST_LOAD_X;
                    end
                end
                ST_LOAD_X: begin
                    if (w_req) begin
                        r_i <= r_i + ONE;
                        if (r_i == r_size_x - ONE) r_last <= 1'b1;
                    end
                    if (w_phase_end) begin
                        r_last  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: r_state <= ST_WAIT_READY;
                ST_WAIT_READY: begin
                    if (READY) begin
                        r_i     <= '0;
                        r_state <= ST_STORE_H;
                    end
                end
                ST_STORE_H: begin
                    // r_last is high during the final write, so DONE follows it by one cycle.
                    if (r_last) begin
                        r_last  <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (H_OUT_ENABLE) begin
                        r_wr    <= 1'b1;
                        r_waddr <= H_BASE + r_i[ADDR_SIZE-1:0];
                        r_wdata <= H_OUT;
                        r_i     <= r_i + ONE;
                        if (r_i == r_size_l - ONE) r_last <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign MEM_RD        = w_f_rd;
    assign MEM_WR        = r_wr;
    assign MEM_ADDR      = r_wr ? r_waddr : (w_f_rd ? w_f_addr : '0);
    assign MEM_WDATA     = r_wdata;
    assign START         = (r_state == ST_RUN);
    assign W_IN_X_ENABLE = (r_state == ST_LOAD_W) && w_f_valid;
    assign W_IN_L_ENABLE = W_IN_X_ENABLE && r_tag_row;
    assign W_IN          = w_f_data;
    assign B_IN_ENABLE   = (r_state == ST_LOAD_B) && w_f_valid;
    assign B_IN          = w_f_data;
    assign X_IN_ENABLE   = (r_state == ST_LOAD_X) && w_f_valid;
    assign X_IN          = w_f_data;
    assign CMD_BUSY      = (r_state != ST_IDLE);
    assign CMD_DONE      = (r_state == ST_DONE);
    assign CMD_ERROR     = CMD_DONE && r_err;
    assign DBG_STATE     = r_state;

endmodule

// File: tb/tb_model_transformer_scheduler.sv
module tb_model_transformer_scheduler;

  localparam int EW = 84;  // event word: {type[3:0], addr[15:0], data[63:0]}

  logic        CLK, RST, CMD_START;
  logic [63:0] SIZE_X_IN, SIZE_L_IN;
  logic        CMD_BUSY, CMD_DONE, CMD_ERROR, MEM_RD, MEM_WR;
  logic [15:0] MEM_ADDR;
  logic [63:0] MEM_WDATA, MEM_RDATA;
  logic        MEM_VALID, START, READY;
  logic        W_IN_L_ENABLE, W_IN_X_ENABLE, B_IN_ENABLE, X_IN_ENABLE, H_OUT_ENABLE;
  logic [63:0] W_IN, B_IN, X_IN, H_OUT;
  logic [2:0]  DBG_STATE;

  model_transformer_scheduler dut (
    .CLK(CLK), .RST(RST), .CMD_START(CMD_START), .SIZE_X_IN(SIZE_X_IN), .SIZE_L_IN(SIZE_L_IN),
    .CMD_BUSY(CMD_BUSY), .CMD_DONE(CMD_DONE), .CMD_ERROR(CMD_ERROR),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_VALID(MEM_VALID), .START(START), .READY(READY),
    .W_IN_L_ENABLE(W_IN_L_ENABLE), .W_IN_X_ENABLE(W_IN_X_ENABLE), .W_IN(W_IN),
    .B_IN_ENABLE(B_IN_ENABLE), .B_IN(B_IN), .X_IN_ENABLE(X_IN_ENABLE), .X_IN(X_IN),
    .H_OUT_ENABLE(H_OUT_ENABLE), .H_OUT(H_OUT), .DBG_STATE(DBG_STATE)
  );

  typedef struct {
    int sx; int sl; int lat_lo; int lat_hi;
    bit spur; bit ready_in_run; bit start_noise; bit b2b; bit exp_err;
  } vec_t;

  vec_t tbl[6];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int rd_overlap = 0;
  int both_cnt = 0;
  int lat_lo = 1, lat_hi = 1;
  bit spur_en = 0, ready_in_run = 0, b2b = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  int wr_cyc_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] ev(input logic [3:0] t, input logic [15:0] a, input logic [63:0] d);
    return {t, a, d};
  endfunction

  function automatic logic [63:0] mem_val(input logic [15:0] a);
    if (a < 16'h4000)      return 64'(a) + 64'd1;
    else if (a < 16'h6000) return 64'(a - 16'h4000) + 64'd5;
    else if (a < 16'h8000) return 64'(a - 16'h6000) + 64'd7;
    else                   return 64'hEEEE;
  endfunction

  task automatic check_eq(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic build_exp(input int sx, input int sl, input bit err);
    logic [15:0] a;
    exp_q.delete();
    if (!err) begin
      for (int l = 0; l < sl; l++)
        for (int x = 0; x < sx; x++) begin
          a = 16'(l * sx + x);
          exp_q.push_back(ev(4'h1, a, 64'h0));
          exp_q.push_back(ev((x == 0) ? 4'hB : 4'h9, 16'h0, mem_val(a)));
        end
      for (int i = 0; i < sl; i++) begin
        a = 16'h4000 + 16'(i);
        exp_q.push_back(ev(4'h1, a, 64'h0));
        exp_q.push_back(ev(4'h2, 16'h0, mem_val(a)));
      end
      for (int i = 0; i < sx; i++) begin
        a = 16'h6000 + 16'(i);
        exp_q.push_back(ev(4'h1, a, 64'h0));
        exp_q.push_back(ev(4'h3, 16'h0, mem_val(a)));
      end
      exp_q.push_back(ev(4'h4, 16'h0, 64'h0));
      for (int i = 0; i < sl; i++)
        exp_q.push_back(ev(4'h5, 16'h8000 + 16'(i), 64'(9 + i)));
    end
    exp_q.push_back(ev(4'h6, 16'h0, {63'b0, err}));
  endtask

  // ---------------- memory model ----------------
  initial begin : mem_model
    logic [15:0] a;
    int lat;
    MEM_VALID = 1'b0;
    MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      MEM_VALID = 1'b0;
      if (MEM_RD) begin
        a = MEM_ADDR;
        lat = $urandom_range(lat_hi, lat_lo);
        repeat (lat - 1) begin
          @(negedge CLK);
          if (MEM_RD) rd_overlap++;
        end
        @(negedge CLK);
        if (MEM_RD) rd_overlap++;
        MEM_VALID = 1'b1;
        MEM_RDATA = mem_val(a);
      end else if (spur_en && $urandom_range(3, 0) == 0) begin
        MEM_VALID = 1'b1;
        MEM_RDATA = 64'hDEAD_BEEF;
      end
    end
  end

  // ---------------- controller model ----------------
  int ctl_sl = 0;
  initial begin : ctl_model
    READY = 1'b0;
    H_OUT_ENABLE = 1'b0;
    H_OUT = '0;
    forever begin
      @(negedge CLK);
      if (START) begin
        if (ready_in_run) READY = 1'b1;   // lands on the RUN cycle edge
        @(negedge CLK);
        READY = 1'b0;
        if (ready_in_run) begin
          H_OUT_ENABLE = 1'b1;             // stray result strobe while waiting
          H_OUT = 64'hBAD;
          @(negedge CLK);
          H_OUT_ENABLE = 1'b0;
          repeat (3) @(negedge CLK);
        end else begin
          repeat (2) @(negedge CLK);
        end
        READY = 1'b1;
        @(negedge CLK);
        READY = 1'b0;
        for (int i = 0; i < ctl_sl; i++) begin
          if (!b2b) repeat ($urandom_range(2, 0)) @(negedge CLK);
          H_OUT_ENABLE = 1'b1;
          H_OUT = 64'(9 + i);
          @(negedge CLK);
          H_OUT_ENABLE = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (MEM_RD) got_q.push_back(ev(4'h1, MEM_ADDR, 64'h0));
    if (W_IN_X_ENABLE || W_IN_L_ENABLE)
      got_q.push_back(ev({2'b10, W_IN_L_ENABLE, W_IN_X_ENABLE}, 16'h0, W_IN));
    if (B_IN_ENABLE) got_q.push_back(ev(4'h2, 16'h0, B_IN));
    if (X_IN_ENABLE) got_q.push_back(ev(4'h3, 16'h0, X_IN));
    if (START) got_q.push_back(ev(4'h4, 16'h0, 64'h0));
    if (MEM_WR) begin
      got_q.push_back(ev(4'h5, MEM_ADDR, MEM_WDATA));
      wr_cyc_q.push_back(cyc);
    end
    if (CMD_DONE) begin
      got_q.push_back(ev(4'h6, 16'h0, {63'b0, CMD_ERROR}));
      done_cyc <= cyc;
    end
    if (MEM_RD && MEM_WR) both_cnt++;
  end

  // ---------------- driver: one pass ----------------
  task automatic run_pass(input vec_t v, input string name);
    int base, wbase, n, noise_at, ncmp;
    lat_lo = v.lat_lo;
    lat_hi = v.lat_hi;
    spur_en = v.spur;
    ready_in_run = v.ready_in_run;
    b2b = v.b2b;
    ctl_sl = v.sl;
    build_exp(v.sx, v.sl, v.exp_err);
    base = got_q.size();
    wbase = wr_cyc_q.size();
    noise_at = -10;
    @(negedge CLK);
    SIZE_X_IN = 64'(v.sx);
    SIZE_L_IN = 64'(v.sl);
    CMD_START = 1'b1;
    start_cyc = cyc;
    @(negedge CLK);
    CMD_START = 1'b0;
    for (n = 0; n < 3000 && !CMD_DONE; n++) begin
      if (v.start_noise) begin
        CMD_START = (n == 4) || (n == noise_at);
        if (START) noise_at = n + 1;
      end
      @(negedge CLK);
    end
    CMD_START = 1'b0;
    check_eq({name, "_done_seen"}, EW'(CMD_DONE), EW'(1));
    check_eq({name, "_error_flag"}, EW'(CMD_ERROR), EW'(v.exp_err));
    check_eq({name, "_busy_at_done"}, EW'(CMD_BUSY), EW'(1));
    @(negedge CLK);
    check_eq({name, "_busy_after_done"}, EW'(CMD_BUSY), EW'(0));
    check_eq({name, "_state_idle"}, EW'(DBG_STATE), EW'(0));
    repeat (4) @(negedge CLK);
    check_eq({name, "_event_count"}, EW'(got_q.size() - base), EW'(exp_q.size()));
    ncmp = (got_q.size() - base < exp_q.size()) ? got_q.size() - base : exp_q.size();
    for (int k = 0; k < ncmp; k++)
      check_eq($sformatf("%s_ev%0d", name, k), got_q[base + k], exp_q[k]);
    if (v.exp_err)
      check_eq({name, "_done_latency"}, EW'(done_cyc - start_cyc), EW'(1));
    if (v.b2b && (wr_cyc_q.size() - wbase == v.sl)) begin
      for (int k = 1; k < v.sl; k++)
        check_eq($sformatf("%s_wr_gap%0d", name, k),
                 EW'(wr_cyc_q[wbase + k] - wr_cyc_q[wbase + k - 1]), EW'(1));
      check_eq({name, "_done_after_last_wr"},
               EW'(done_cyc - wr_cyc_q[wbase + v.sl - 1]), EW'(1));
    end
  endtask

  // ---------------- main ----------------
  initial begin : main
    int n;
    vec_t v;
    RST = 1'b0;
    CMD_START = 1'b0;
    SIZE_X_IN = '0;
    SIZE_L_IN = '0;

    //          sx sl lo hi spur rir noise b2b err
    tbl[0] = '{2, 2, 1, 1, 0, 0, 0, 0, 0};  // basic exact sequence
    tbl[1] = '{0, 3, 1, 1, 0, 0, 0, 0, 1};  // zero SIZE_X
    tbl[2] = '{2, 2, 1, 5, 1, 0, 0, 0, 0};  // random latency, spurious valid
    tbl[3] = '{2, 2, 1, 2, 0, 1, 1, 0, 0};  // start noise, READY in RUN
    tbl[4] = '{3, 4, 1, 1, 0, 0, 0, 1, 0};  // back-to-back results, row wrap
    tbl[5] = '{3, 0, 1, 3, 0, 0, 0, 0, 1};  // zero SIZE_L

    repeat (3) @(negedge CLK);
    check_eq("reset_state", EW'(DBG_STATE), EW'(0));
    check_eq("reset_ctrl_outputs",
             EW'({CMD_BUSY, CMD_DONE, CMD_ERROR, MEM_RD, MEM_WR, START}), EW'(0));
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 6; i++) run_pass(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of LOAD_B.
    lat_lo = 1; lat_hi = 1; spur_en = 0; ready_in_run = 0; b2b = 0;
    @(negedge CLK);
    SIZE_X_IN = 64'd2;
    SIZE_L_IN = 64'd2;
    CMD_START = 1'b1;
    @(negedge CLK);
    CMD_START = 1'b0;
    for (n = 0; n < 200 && !B_IN_ENABLE; n++) @(negedge CLK);
    check_eq("abort_reached_load_b", EW'(B_IN_ENABLE), EW'(1));
    #1 RST = 1'b0;
    #1;
    check_eq("abort_ctrl_outputs_zero",
             EW'({CMD_BUSY, CMD_DONE, CMD_ERROR, MEM_RD, MEM_WR, START,
                  W_IN_L_ENABLE, W_IN_X_ENABLE, B_IN_ENABLE, X_IN_ENABLE}), EW'(0));
    check_eq("abort_addr_zero", EW'(MEM_ADDR), EW'(0));
    check_eq("abort_data_zero", EW'(MEM_WDATA | W_IN | B_IN | X_IN), EW'(0));
    check_eq("abort_state_idle", EW'(DBG_STATE), EW'(0));
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    v = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    run_pass(v, "after_abort");

    check_eq("single_outstanding_read", EW'(rd_overlap), EW'(0));
    check_eq("rd_wr_exclusive", EW'(both_cnt), EW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/model_transformer_scheduler.md
Name: model_transformer_scheduler

Overview:
Sequencer that drives the load/run/store interface of model_controller for one transformer layer pass. It fetches weights W (L x X), bias B (L) and input X (X) from a word-addressed memory and streams them into the controller with the index-enable strobes. It then pulses START, waits for READY, and writes the L-word H_OUT result back to memory. It sits between the system memory/command port and model_controller, replacing the hand-written stimulus driver.

Parameters:
DATA_SIZE, 64, data word and size-register width
ADDR_SIZE, 16, memory address width
W_BASE, 16'h0000, base address of W (row-major, row l at W_BASE + l*SIZE_X)
B_BASE, 16'h4000, base address of B
X_BASE, 16'h6000, base address of X
H_BASE, 16'h8000, base address for H results

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
CMD_START  in  1  start one pass (sampled in IDLE only)
SIZE_X_IN  in  DATA_SIZE  input vector length, latched on accepted CMD_START
SIZE_L_IN  in  DATA_SIZE  output vector length, latched on accepted CMD_START
CMD_BUSY  out  1  high from accepted start until CMD_DONE cycle inclusive
CMD_DONE  out  1  one-cycle completion pulse
CMD_ERROR  out  1  valid with CMD_DONE; 1 = zero size, nothing executed
MEM_RD  out  1  one-cycle read request
MEM_WR  out  1  one-cycle write request
MEM_ADDR  out  ADDR_SIZE  read/write address
MEM_WDATA  out  DATA_SIZE  write data
MEM_RDATA  in  DATA_SIZE  read data
MEM_VALID  in  1  MEM_RDATA valid; any latency >= 1
START  out  1  one-cycle pulse to controller
READY  in  1  controller completion
W_IN_L_ENABLE, W_IN_X_ENABLE  out  1  weight row / element strobes
W_IN  out  DATA_SIZE  weight word
B_IN_ENABLE  out  1  bias element strobe
B_IN  out  DATA_SIZE  bias word
X_IN_ENABLE  out  1  input element strobe
X_IN  out  DATA_SIZE  input word
H_OUT_ENABLE  in  1  result element strobe from controller
H_OUT  in  DATA_SIZE  result word

Behaviour:
- Reset (RST=0, async): state IDLE, all outputs 0, counters 0. Mid-pass reset aborts immediately. No DONE is issued. The controller is not notified.
- States: IDLE, LOAD_W, LOAD_B, LOAD_X, RUN, WAIT_READY, STORE_H, DONE.
- IDLE: CMD_START=1 latches sizes and asserts CMD_BUSY next cycle. If either size is 0, go to DONE with CMD_ERROR=1: DONE and ERROR pulse 1 cycle after start, no memory or controller activity. Otherwise go to LOAD_W, l=0, x=0.
- Element transfer (LOAD_*), per element:
  - Cycle 1: MEM_RD=1 with MEM_ADDR.
  - Wait for MEM_VALID and register MEM_RDATA.
  - The cycle after MEM_VALID: drive the enable(s) high for exactly 1 cycle with the data word.
  - Next MEM_RD follows in the next cycle. Minimum 3 cycles per element. One read outstanding at most.
  - MEM_VALID while no read is outstanding is ignored.
- LOAD_W: address = W_BASE + l*SIZE_X + x (mod 2^ADDR_SIZE). W_IN_X_ENABLE on every element; W_IN_L_ENABLE concurrently only when x==0. x wraps at SIZE_X-1 and increments l. After (SIZE_L-1, SIZE_X-1), go to LOAD_B.
- LOAD_B: SIZE_L elements, address B_BASE+i, strobe B_IN_ENABLE. Then go to LOAD_X.
- LOAD_X: SIZE_X elements, address X_BASE+i, strobe X_IN_ENABLE. Then go to RUN.
- RUN: START=1 for one cycle, then WAIT_READY. READY sampled only in WAIT_READY. READY=1 goes to STORE_H. READY during RUN is ignored.
- STORE_H: each H_OUT_ENABLE=1 produces, one cycle later, MEM_WR=1, MEM_ADDR=H_BASE+i, MEM_WDATA=H_OUT. After SIZE_L words, go to DONE. H_OUT_ENABLE outside STORE_H is ignored. Back-to-back strobes are accepted every cycle.
- DONE: CMD_DONE=1 one cycle, CMD_BUSY drops next cycle, return to IDLE.
- CMD_START outside IDLE is ignored. MEM_RD and MEM_WR are never high together.
- SIZE_L*SIZE_X beyond 2^ADDR_SIZE wraps addresses. Caller's responsibility; no error is flagged.

Decomposition:
- Package model_transformer_scheduler_pkg: state enum, default base-address constants.
- Sub-module model_transformer_scheduler_fetch: single-outstanding read engine (addr in, req, data/valid out) reused by all three LOAD states.

Test Plan:
1. SIZE_X=2, SIZE_L=2, W=[1,2,3,4], B=[5,6], X=[7,8], MEM latency 1 -> exact sequence:
   - W strobes 1,2,3,4, with L_ENABLE on 1 and 3.
   - B 5,6, then X 7,8, then one START pulse.
   - Controller returns READY then H=[9,10] -> MEM_WR 9@8000, 10@8001, then CMD_DONE with ERROR=0.
2. SIZE_X=0, SIZE_L=3, CMD_START -> CMD_DONE & CMD_ERROR 1 cycle later; zero MEM_RD, zero START.
3. MEM latency randomized 1-5 with spurious MEM_VALID in STORE_H -> data order identical to test 1; spurious valid has no effect.
4. CMD_START pulses during LOAD_W and WAIT_READY, and READY asserted during RUN -> no restart, no early STORE_H.
5. RST=0 asynchronously during LOAD_B -> all outputs 0 before next edge; a new pass with SIZE_X=1, SIZE_L=1 completes normally.
6. SIZE_L=4, H_OUT_ENABLE on 4 consecutive cycles -> 4 consecutive MEM_WR at 8000..8003, CMD_DONE on the cycle after the last write.
